// File: rtl/multimode_ff_bank.sv
// multimode_ff_bank: WIDTH-bit flip-flop bank with run-time SR/JK/D/T mode,
// build-time resolution of S=R=1, per-bit illegal flags, a sticky error and
// a saturating illegal-event counter.
module multimode_ff_bank #(
  parameter int unsigned         WIDTH     = 4,
  parameter logic [WIDTH-1:0]    RESET_VAL = '0,
  parameter int                  SR_POLICY = 0,
  parameter int unsigned         CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] illegal_mask,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } ff_mode_e;

  // Reject unsupported S=R=1 policies when the bank is elaborated.
  generate
    if (SR_POLICY < 0 || SR_POLICY > 3) begin : g_bad_policy
      $error("multimode_ff_bank: SR_POLICY must be 0..3");
    end
  endgenerate

  ff_mode_e         cur_mode;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] illegal_next;
  logic             event_hit;
  logic [CNT_W-1:0] count_base;
  logic [CNT_W-1:0] count_next;

  assign cur_mode = ff_mode_e'(mode);
  assign q_bar    = ~q;

  // Per-bit next state for the selected mode, plus illegal S=R=1 detection.
  always_comb begin
    q_next       = q;
    illegal_next = '0;
    if (en) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        unique case (cur_mode)
          MODE_SR: begin
            unique case ({a[i], b[i]})
              2'b00: q_next[i] = q[i];
              2'b10: q_next[i] = 1'b1;
              2'b01: q_next[i] = 1'b0;
              default: begin
                illegal_next[i] = 1'b1;
                case (SR_POLICY)
                  1:       q_next[i] = 1'b0;
                  2:       q_next[i] = 1'b1;
                  3:       q_next[i] = ~q[i];
                  default: q_next[i] = q[i];
                endcase
              end
            endcase
          end
          MODE_JK: begin
            unique case ({a[i], b[i]})
              2'b00:   q_next[i] = q[i];
              2'b10:   q_next[i] = 1'b1;
              2'b01:   q_next[i] = 1'b0;
              default: q_next[i] = ~q[i];
            endcase
          end
          MODE_D:  q_next[i] = a[i];
          default: q_next[i] = a[i] ? ~q[i] : q[i];
        endcase
      end
    end
  end

  // Clear is applied before the event is counted, so clear+event yields 1.
  always_comb begin
    event_hit  = |illegal_next;
    count_base = clr_err ? '0 : err_count;
    count_next = count_base;
    if (event_hit && (count_base != '1)) begin
      count_next = count_base + 1'b1;
    end
  end

  // State and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q            <= RESET_VAL;
      illegal_mask <= '0;
      err_sticky   <= 1'b0;
      err_count    <= '0;
    end else begin
      q            <= q_next;
      illegal_mask <= illegal_next;
      if (event_hit) begin
        err_sticky <= 1'b1;
      end else if (clr_err) begin
        err_sticky <= 1'b0;
      end
      err_count <= count_next;
    end
  end

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Directed bench for multimode_ff_bank: four instances differing only in
// SR_POLICY share one stimulus stream; CNT_W=2 exposes saturation quickly.
module tb_multimode_ff_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [3:0] a;
  logic [3:0] b;
  logic       clr_err;

  logic [3:0] q      [4];
  logic [3:0] q_bar  [4];
  logic [3:0] mask   [4];
  logic       sticky [4];
  logic [1:0] cnt    [4];

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] M_SR = 2'b00;
  localparam logic [1:0] M_JK = 2'b01;
  localparam logic [1:0] M_D  = 2'b10;
  localparam logic [1:0] M_T  = 2'b11;

  always #5 clk = ~clk;

  for (genvar p = 0; p < 4; p++) begin : g_dut
    multimode_ff_bank #(
      .WIDTH     (4),
      .RESET_VAL (4'h5),
      .SR_POLICY (p),
      .CNT_W     (2)
    ) dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .mode         (mode),
      .a            (a),
      .b            (b),
      .clr_err      (clr_err),
      .q            (q[p]),
      .q_bar        (q_bar[p]),
      .illegal_mask (mask[p]),
      .err_sticky   (sticky[p]),
      .err_count    (cnt[p])
    );
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, then wait one rising edge and settle before sampling.
  task automatic step(input logic rst_n, input logic e, input logic [1:0] m,
                      input logic [3:0] av, input logic [3:0] bv, input logic clr);
    reset = rst_n; en = e; mode = m; a = av; b = bv; clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input int p, input logic [3:0] m,
                              input logic s, input logic [1:0] c);
    check({tag, "_mask"},   mask[p],   m);
    check({tag, "_sticky"}, sticky[p], s);
    check({tag, "_cnt"},    cnt[p],    c);
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; mode = M_D; a = 4'hF; b = 4'h0; clr_err = 1'b0;
    #2;

    // Reset held for two edges while D-mode inputs would load F.
    step(1'b0, 1'b1, M_D, 4'hF, 4'h0, 1'b0);
    step(1'b0, 1'b1, M_D, 4'hF, 4'h0, 1'b0);
    for (int p = 0; p < 4; p++) check($sformatf("rst_q%0d", p), q[p], 4'h5);
    check("rst_qbar", q_bar[0], 4'hA);
    check_status("rst", 0, 4'h0, 1'b0, 2'd0);

    step(1'b1, 1'b1, M_D, 4'hF, 4'h0, 1'b0);
    check("rel_q", q[0], 4'hF);
    check("rel_qbar", q_bar[0], 4'h0);

    // SR basic.
    step(1'b1, 1'b1, M_D,  4'h0, 4'h0, 1'b0);
    check("d0_q", q[0], 4'h0);
    step(1'b1, 1'b1, M_SR, 4'b0011, 4'b0000, 1'b0);
    check("sr_set_q", q[0], 4'b0011);
    step(1'b1, 1'b1, M_SR, 4'b0000, 4'b0001, 1'b0);
    check("sr_clr_q", q[0], 4'b0010);
    step(1'b1, 1'b0, M_SR, 4'hF, 4'hF, 1'b0);
    check("en0_q", q[0], 4'b0010);
    check_status("en0", 0, 4'h0, 1'b0, 2'd0);

    // S=R=1 under each policy from q=0101.
    step(1'b1, 1'b1, M_D, 4'b0101, 4'h0, 1'b0);
    check("pol_pre_q", q[3], 4'b0101);
    step(1'b1, 1'b1, M_SR, 4'b1100, 4'b1100, 1'b0);
    check("pol0_q", q[0], 4'b0101);
    check("pol1_q", q[1], 4'b0001);
    check("pol2_q", q[2], 4'b1101);
    check("pol3_q", q[3], 4'b1001);
    check("pol3_qbar", q_bar[3], 4'b0110);
    for (int p = 0; p < 4; p++) check_status($sformatf("pol%0d", p), p, 4'b1100, 1'b1, 2'd1);

    // JK toggle; status holds, mask drops.
    step(1'b1, 1'b1, M_D,  4'h3, 4'h0, 1'b0);
    check("jk_pre_q", q[0], 4'h3);
    step(1'b1, 1'b1, M_JK, 4'hF, 4'hF, 1'b0);
    check("jk_q", q[0], 4'hC);
    check_status("jk", 0, 4'h0, 1'b1, 2'd1);
    step(1'b1, 1'b1, M_JK, 4'b0110, 4'b1001, 1'b0);
    check("jk_setclr_q", q[0], 4'b0110);

    // T mode on bit 0 (b ignored).
    step(1'b1, 1'b1, M_D, 4'h0, 4'h0, 1'b0);
    step(1'b1, 1'b1, M_T, 4'h1, 4'hF, 1'b0);
    check("t1_q", q[0], 4'h1);
    step(1'b1, 1'b1, M_T, 4'h1, 4'hF, 1'b0);
    check("t2_q", q[0], 4'h0);
    step(1'b1, 1'b1, M_T, 4'h1, 4'hF, 1'b0);
    check("t3_q", q[0], 4'h1);

    step(1'b1, 1'b1, M_D, 4'h9, 4'hF, 1'b0);
    check("d9_q", q[0], 4'h9);

    // clr_err alone clears sticky and count.
    step(1'b1, 1'b0, M_SR, 4'hF, 4'hF, 1'b1);
    check_status("clr1", 0, 4'h0, 1'b0, 2'd0);

    // Saturation: multi-bit illegal edges count once each.
    step(1'b1, 1'b1, M_SR, 4'hF, 4'hF, 1'b0);
    check_status("sat1", 0, 4'hF, 1'b1, 2'd1);
    check("sat1_q", q[0], 4'h9);
    step(1'b1, 1'b1, M_SR, 4'hF, 4'hF, 1'b0);
    check("sat2_cnt", cnt[0], 2'd2);
    step(1'b1, 1'b1, M_SR, 4'hF, 4'hF, 1'b0);
    check("sat3_cnt", cnt[0], 2'd3);
    step(1'b1, 1'b1, M_SR, 4'hF, 4'hF, 1'b0);
    check("sat4_cnt", cnt[0], 2'd3);
    step(1'b1, 1'b1, M_SR, 4'hF, 4'hF, 1'b0);
    check("sat5_cnt", cnt[0], 2'd3);
    check("sat5_cnt_p3", cnt[3], 2'd3);

    // Clear racing an illegal edge: clear first, then count.
    step(1'b1, 1'b1, M_SR, 4'b0001, 4'b0001, 1'b1);
    check_status("race", 0, 4'b0001, 1'b1, 2'd1);
    step(1'b1, 1'b0, M_SR, 4'h0, 4'h0, 1'b1);
    check_status("clr2", 0, 4'h0, 1'b0, 2'd0);

    // Reset on the same edge as an illegal event wins.
    step(1'b1, 1'b1, M_SR, 4'b0010, 4'b0010, 1'b0);
    check_status("pre_rst", 0, 4'b0010, 1'b1, 2'd1);
    step(1'b0, 1'b1, M_SR, 4'hF, 4'hF, 1'b0);
    check_status("rst_evt", 0, 4'h0, 1'b0, 2'd0);
    check("rst_evt_q", q[3], 4'h5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
